// File: rtl/cmd_controller.sv
// SD CMD-line transaction sequencer: frames a command with CRC7, drives the serializer,
// then waits (bounded by NCR_MAX) for the card's response and shifts it in.
module cmd_controller #(
  parameter int FRAME_BITS = 48,
  parameter int NCR_MAX    = 64,
  parameter int RSP_LONG   = 136
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [5:0]          cmd_index,
  input  logic [31:0]         cmd_arg,
  input  logic [1:0]          rsp_type,
  output logic [47:0]         ser_in,
  output logic                ser_reset,
  output logic                ser_enable,
  output logic                cmd_oe,
  input  logic                cmd_in,
  output logic [RSP_LONG-1:0] rsp_data,
  output logic                done,
  output logic                timeout
);

  localparam logic [7:0] SendLast  = 8'(FRAME_BITS - 1);
  localparam logic [7:0] NcrLast   = 8'(NCR_MAX);
  localparam logic [7:0] ShortLast = 8'(48 - 1);
  localparam logic [7:0] LongLast  = 8'(RSP_LONG - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StSend, StWait, StRecv, StDone
  } state_e;

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic                rspNone_q;
  logic                rspLong_q;
  logic                cmdReady_q;
  logic [47:0]         serIn_q;
  logic                serReset_q;
  logic                serEnable_q;
  logic                cmdOe_q;
  logic [RSP_LONG-1:0] rspData_q;
  logic                done_q;
  logic                timeout_q;
  logic [47:0]         frame_d;

  // Serial CRC7 (x^7 + x^3 + 1, init 0) over the 40 header bits, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always_comb begin
    frame_d = {2'b01, cmd_index, cmd_arg, crc7({2'b01, cmd_index, cmd_arg}), 1'b1};
  end

  // The frame is built straight from the request so it is already valid while ser_reset pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rspNone_q   <= 1'b0;
      rspLong_q   <= 1'b0;
      cmdReady_q  <= 1'b1;
      serIn_q     <= '0;
      serReset_q  <= 1'b0;
      serEnable_q <= 1'b0;
      cmdOe_q     <= 1'b0;
      rspData_q   <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      serReset_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmdReady_q <= 1'b0;
            serReset_q <= 1'b1;
            serIn_q    <= frame_d;
            rspData_q  <= '0;
            rspNone_q  <= (rsp_type == 2'd0);
            rspLong_q  <= (rsp_type == 2'd2);
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          serEnable_q <= 1'b1;
          cmdOe_q     <= 1'b1;
          cnt_q       <= '0;
          state_q     <= StSend;
        end
        StSend: begin
          if (cnt_q == SendLast) begin
            serEnable_q <= 1'b0;
            cmdOe_q     <= 1'b0;
            if (rspNone_q) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= StDone;
            end else begin
              cnt_q   <= 8'd1;
              state_q <= StWait;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        // A start bit on the final allowed cycle still wins over the timeout.
        StWait: begin
          if (!cmd_in) begin
            rspData_q <= {rspData_q[RSP_LONG-2:0], cmd_in};
            cnt_q     <= 8'd1;
            state_q   <= StRecv;
          end else if (cnt_q == NcrLast) begin
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StRecv: begin
          rspData_q <= {rspData_q[RSP_LONG-2:0], cmd_in};
          if (cnt_q == (rspLong_q ? LongLast : ShortLast)) begin
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          cmdReady_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = cmdReady_q;
  assign ser_in     = serIn_q;
  assign ser_reset  = serReset_q;
  assign ser_enable = serEnable_q;
  assign cmd_oe     = cmdOe_q;
  assign rsp_data   = rspData_q;
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_cmd_controller.sv
// Self-checking bench for cmd_controller: table of command vectors with a response scoreboard,
// plus hand-written reset and back-to-back sequences.
module tb_cmd_controller;

  localparam int NCR_MAX  = 64;
  localparam int RSP_LONG = 136;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [5:0]          cmd_index;
  logic [31:0]         cmd_arg;
  logic [1:0]          rsp_type;
  logic [47:0]         ser_in;
  logic                ser_reset;
  logic                ser_enable;
  logic                cmd_oe;
  logic                cmd_in;
  logic [RSP_LONG-1:0] rsp_data;
  logic                done;
  logic                timeout;

  always #5 clk = ~clk;

  cmd_controller #(.FRAME_BITS(48), .NCR_MAX(NCR_MAX), .RSP_LONG(RSP_LONG)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .rsp_type(rsp_type), .ser_in(ser_in),
    .ser_reset(ser_reset), .ser_enable(ser_enable), .cmd_oe(cmd_oe), .cmd_in(cmd_in),
    .rsp_data(rsp_data), .done(done), .timeout(timeout)
  );

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    int           startCycle;
    logic [135:0] pattern;
    logic         pulseValid;
    logic [47:0]  expFrame;
    logic [135:0] expRsp;
    logic         expTimeout;
  } vec_t;

  typedef struct {
    logic [135:0] rsp;
    logic         to;
    int           doneCycle;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [135:0] LongPat = 136'h3F_0123456789ABCDEF_FEDCBA9876543211;

  // CRC as polynomial remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] benchCrc7(input logic [39:0] msg);
    logic [46:0] m;
    m = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic logic [47:0] benchFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, benchCrc7(h), 1'b1};
  endfunction

  task automatic checkOutput(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic waitDone(input int budget, output int seen);
    seen = 0;
    for (int c = 1; c <= budget && seen == 0; c++) begin
      if (done) seen = c;
      else @(negedge clk);
    end
  endtask

  // Runs one command, plays the card's response and scores it against the queued expectation.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    exp_t got;
    int   len;
    int   en;
    int   doneAt;
    len = (v.rtype == 2'd2) ? 136 : 48;
    e.rsp = v.expRsp;
    e.to  = v.expTimeout;
    e.doneCycle = (v.rtype == 2'd0) ? 1 : ((v.startCycle == 0) ? NCR_MAX + 1 : v.startCycle + len);
    checkBit("ready_idle", cmd_ready, 1'b1);
    cmd_index = v.idx;
    cmd_arg   = v.arg;
    rsp_type  = v.rtype;
    cmd_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkBit("ser_reset_load", ser_reset, 1'b1);
    checkOutput("ser_in", {88'd0, ser_in}, {88'd0, v.expFrame});
    checkBit("enable_load", ser_enable, 1'b0);
    checkOutput("rsp_clear", rsp_data, 136'd0);
    checkBit("ready_busy", cmd_ready, 1'b0);
    @(negedge clk);
    checkBit("ser_reset_pulse", ser_reset, 1'b0);
    en = 0;
    while (ser_enable && cmd_oe && en < 200) begin
      en++;
      if (v.pulseValid) cmd_valid = en[1];
      @(negedge clk);
    end
    checkOutput("send_len", 136'(en), 136'(48));
    checkBit("oe_released", cmd_oe, 1'b0);
    doneAt = 0;
    for (int c = 1; c <= 400 && doneAt == 0; c++) begin
      if (done) doneAt = c;
      else begin
        cmd_in = 1'b1;
        if (v.startCycle != 0 && c >= v.startCycle && c - v.startCycle < len)
          cmd_in = v.pattern[len - 1 - (c - v.startCycle)];
        if (v.pulseValid) begin
          cmd_valid = (c < 10);
          if (c == 5) checkBit("ready_wait", cmd_ready, 1'b0);
        end
        @(negedge clk);
      end
    end
    cmd_in    = 1'b1;
    cmd_valid = 1'b0;
    got = sb.pop_front();
    checkOutput("done_cycle", 136'(doneAt), 136'(got.doneCycle));
    checkOutput("rsp_data", rsp_data, got.rsp);
    checkBit("timeout", timeout, got.to);
    @(negedge clk);
    checkBit("done_pulse", done, 1'b0);
    checkBit("ready_back", cmd_ready, 1'b1);
    checkOutput("rsp_hold", rsp_data, got.rsp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   seen;
    vecs[0] = '{6'd0, 32'd0, 2'd0, 0, 136'd0, 1'b0, 48'h400000000095, 136'd0, 1'b0};
    vecs[1] = '{6'd8, 32'h1AA, 2'd1, 5, {88'd0, 48'h08000001AA13}, 1'b0, 48'h48000001AA87,
                {88'd0, 48'h08000001AA13}, 1'b0};
    vecs[2] = '{6'd17, 32'h12345678, 2'd1, 0, 136'd0, 1'b1, benchFrame(6'd17, 32'h12345678),
                136'd0, 1'b1};
    vecs[3] = '{6'd2, 32'd0, 2'd2, NCR_MAX, LongPat, 1'b0, benchFrame(6'd2, 32'd0), LongPat, 1'b0};
    vecs[4] = '{6'd13, 32'hDEADBEEF, 2'd3, 1, {88'd0, 48'h0D00000009AB}, 1'b0,
                benchFrame(6'd13, 32'hDEADBEEF), {88'd0, 48'h0D00000009AB}, 1'b0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; rsp_type = '0; cmd_in = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_ser_in", {88'd0, ser_in}, 136'd0);
    checkOutput("rst_rsp", rsp_data, 136'd0);
    checkBit("rst_oe", cmd_oe, 1'b0);
    checkBit("rst_en", ser_enable, 1'b0);
    checkBit("rst_done", done, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkBit("rst_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Reset while the response is being shifted in.
    cmd_index = 6'd3; cmd_arg = 32'h5; rsp_type = 2'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 60 && (ser_enable || ser_reset || c == 0); c++) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      cmd_in = (c == 0) ? 1'b0 : c[0];
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    checkOutput("rst_recv_rsp", rsp_data, 136'd0);
    checkOutput("rst_recv_ser", {88'd0, ser_in}, 136'd0);
    checkBit("rst_recv_done", done, 1'b0);
    checkBit("rst_recv_to", timeout, 1'b0);
    checkBit("rst_recv_oe", cmd_oe, 1'b0);
    @(negedge clk);
    reset = 1'b1; cmd_in = 1'b1;
    @(negedge clk);
    checkBit("rst_recv_ready", cmd_ready, 1'b1);

    // Asynchronous reset in the middle of SEND, between clock edges.
    cmd_index = 6'd0; cmd_arg = 32'd0; rsp_type = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkBit("send_active", ser_enable, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkBit("async_oe", cmd_oe, 1'b0);
    checkBit("async_en", ser_enable, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // cmd_valid held across two commands: second accept only after DONE returns to IDLE.
    cmd_index = 6'd0; cmd_arg = 32'd0; rsp_type = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    checkOutput("b2b_frame0", {88'd0, ser_in}, {88'd0, 48'h400000000095});
    waitDone(100, seen);
    checkBit("b2b_done0", done, 1'b1);
    cmd_index = 6'd8; cmd_arg = 32'h1AA; rsp_type = 2'd1;
    @(negedge clk);
    checkBit("b2b_idle_ready", cmd_ready, 1'b1);
    checkBit("b2b_no_load_in_done", ser_reset, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkBit("b2b_load", ser_reset, 1'b1);
    checkBit("b2b_busy", cmd_ready, 1'b0);
    checkOutput("b2b_frame1", {88'd0, ser_in}, {88'd0, 48'h48000001AA87});
    waitDone(300, seen);
    checkBit("b2b_timeout", timeout, 1'b1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
